// File: rtl/core_pwr_seq.sv
// Power sequencer for one compute core: PLL bring-up with lock timeout, then timed
// clock-enable and reset release; power-down walks the same steps in reverse.
module core_pwr_seq #(
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CLK_SETTLE   = 16,
  parameter int unsigned RST_HOLD     = 8
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        pwr_req_i,
  input  logic [3:0]  pll_ref_div_i,
  input  logic [11:0] pll_fb_div_i,
  input  logic        pll_locked_i,
  input  logic        err_clr_i,
  output logic [3:0]  pll_ref_div_o,
  output logic [11:0] pll_fb_div_o,
  output logic        pll_en_o,
  output logic        core_clk_en_o,
  output logic        core_rst_no,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned MAX_A   = (LOCK_TIMEOUT > CLK_SETTLE) ? LOCK_TIMEOUT : CLK_SETTLE;
  localparam int unsigned MAX_ALL = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLK_SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_LOST    = 2'b10;

  typedef enum logic [3:0] {
    S_OFF, S_PLL_CFG, S_PLL_WAIT, S_CLK_SETTLE, S_RST_HOLD,
    S_RUN, S_RST_ASSERT, S_CLK_OFF, S_PLL_OFF, S_ERR
  } state_e;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       ref_div_reg;
  logic [11:0]      fb_div_reg;
  logic             err_reg, err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic             latch_div;
  logic             timed_state;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg    <= S_OFF;
      cnt_reg      <= '0;
      ref_div_reg  <= '0;
      fb_div_reg   <= '0;
      err_reg      <= 1'b0;
      err_code_reg <= CODE_NONE;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      if (latch_div) begin
        ref_div_reg <= pll_ref_div_i;
        fb_div_reg  <= pll_fb_div_i;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    err_next      = err_reg;
    err_code_next = err_code_reg;
    latch_div     = 1'b0;
    case (state_reg)
      S_OFF: begin
        if (pwr_req_i) begin
          state_next = S_PLL_CFG;
          latch_div  = 1'b1;
        end
      end
      S_PLL_CFG: state_next = S_PLL_WAIT;
      S_PLL_WAIT: begin
        // Abort beats lock, and lock beats timeout in the same cycle.
        if (!pwr_req_i) begin
          state_next = S_PLL_OFF;
        end else if (pll_locked_i) begin
          state_next = S_CLK_SETTLE;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next    = S_ERR;
          err_next      = 1'b1;
          err_code_next = CODE_TIMEOUT;
        end
      end
      S_CLK_SETTLE: begin
        if (!pwr_req_i)                 state_next = S_CLK_OFF;
        else if (cnt_reg == SETTLE_LAST) state_next = S_RST_HOLD;
      end
      S_RST_HOLD: begin
        if (!pwr_req_i)               state_next = S_CLK_OFF;
        else if (cnt_reg == HOLD_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (!pll_locked_i) begin
          state_next    = S_RST_ASSERT;
          err_next      = 1'b1;
          err_code_next = CODE_LOST;
        end else if (!pwr_req_i) begin
          state_next = S_RST_ASSERT;
        end
      end
      S_RST_ASSERT: if (cnt_reg == HOLD_LAST)   state_next = S_CLK_OFF;
      S_CLK_OFF:    if (cnt_reg == SETTLE_LAST) state_next = S_PLL_OFF;
      S_PLL_OFF:    state_next = err_reg ? S_ERR : S_OFF;
      S_ERR: begin
        if (err_clr_i) begin
          state_next    = S_OFF;
          err_next      = 1'b0;
          err_code_next = CODE_NONE;
        end
      end
      default: state_next = S_OFF;
    endcase

    timed_state = (state_reg == S_PLL_WAIT) || (state_reg == S_CLK_SETTLE) ||
                  (state_reg == S_RST_HOLD) || (state_reg == S_RST_ASSERT) ||
                  (state_reg == S_CLK_OFF);
    cnt_next = (!timed_state || (state_next != state_reg)) ? '0 : cnt_reg + 1'b1;
  end

  always_comb begin
    pll_en_o      = 1'b0;
    core_clk_en_o = 1'b0;
    core_rst_no   = 1'b0;
    ready_o       = 1'b0;
    busy_o        = 1'b1;
    case (state_reg)
      S_OFF, S_ERR: busy_o = 1'b0;
      S_PLL_WAIT, S_CLK_OFF: pll_en_o = 1'b1;
      S_CLK_SETTLE, S_RST_HOLD, S_RST_ASSERT: begin
        pll_en_o      = 1'b1;
        core_clk_en_o = 1'b1;
      end
      S_RUN: begin
        pll_en_o      = 1'b1;
        core_clk_en_o = 1'b1;
        core_rst_no   = 1'b1;
        ready_o       = 1'b1;
        busy_o        = 1'b0;
      end
      default: ;
    endcase
    // Dividers are held internally but present as zero while powered off.
    pll_ref_div_o = (state_reg == S_OFF) ? 4'h0 : ref_div_reg;
    pll_fb_div_o  = (state_reg == S_OFF) ? 12'h000 : fb_div_reg;
    err_o         = err_reg;
    err_code_o    = err_code_reg;
  end

endmodule

// File: tb/tb_core_pwr_seq.sv
// Directed bench for core_pwr_seq: expected output snapshots are queued per cycle
// while stimulus is driven and compared on the falling edge.
module tb_core_pwr_seq;

  localparam int LT = 32;
  localparam int CS = 4;
  localparam int RH = 8;

  localparam int S_OFF = 0, S_CFG = 1, S_WAIT = 2, S_SETTLE = 3, S_HOLD = 4;
  localparam int S_RUN = 5, S_RASSERT = 6, S_CKOFF = 7, S_PLLOFF = 8, S_ERR = 9;

  localparam logic [23:0] M_ALL   = 24'hFFFFFF;
  localparam logic [23:0] M_NOERR = 24'hFFFFF8;

  logic        clk = 1'b0;
  logic        srst, pwr, locked, err_clr;
  logic [3:0]  ref_in;
  logic [11:0] fb_in;
  logic [3:0]  ref_o;
  logic [11:0] fb_o;
  logic        pll_en, clk_en, rst_n, ready, busy, err;
  logic [1:0]  code;

  core_pwr_seq #(.LOCK_TIMEOUT(LT), .CLK_SETTLE(CS), .RST_HOLD(RH)) dut (
    .clk_i(clk), .srst_i(srst), .pwr_req_i(pwr), .pll_ref_div_i(ref_in),
    .pll_fb_div_i(fb_in), .pll_locked_i(locked), .err_clr_i(err_clr),
    .pll_ref_div_o(ref_o), .pll_fb_div_o(fb_o), .pll_en_o(pll_en),
    .core_clk_en_o(clk_en), .core_rst_no(rst_n), .ready_o(ready),
    .busy_o(busy), .err_o(err), .err_code_o(code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [23:0] v;
    logic [23:0] m;
  } exp_t;
  exp_t sb[$];
  exp_t chk_e;

  logic [23:0] outv;
  assign outv = {ref_o, fb_o, pll_en, clk_en, rst_n, ready, busy, err, code};

  function automatic logic [23:0] ov(input logic [3:0] r, input logic [11:0] f,
                                     input logic pe, input logic ce, input logic rn,
                                     input logic rd, input logic bz, input logic er,
                                     input logic [1:0] cd);
    return {r, f, pe, ce, rn, rd, bz, er, cd};
  endfunction

  // Expected outputs for each state as the datasheet describes them.
  function automatic logic [23:0] sv(input int s, input logic [3:0] r, input logic [11:0] f,
                                     input logic er, input logic [1:0] cd);
    case (s)
      S_OFF:     return 24'h000000;
      S_CFG:     return ov(r, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, er, cd);
      S_WAIT:    return ov(r, f, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, er, cd);
      S_SETTLE:  return ov(r, f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, er, cd);
      S_HOLD:    return ov(r, f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, er, cd);
      S_RUN:     return ov(r, f, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, er, cd);
      S_RASSERT: return ov(r, f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, er, cd);
      S_CKOFF:   return ov(r, f, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, er, cd);
      S_PLLOFF:  return ov(r, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, er, cd);
      S_ERR:     return ov(r, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cd);
      default:   return 24'hFFFFFF;
    endcase
  endfunction

  task automatic expect_at(input int c, input string tag, input int s, input logic [3:0] r,
                           input logic [11:0] f, input logic er, input logic [1:0] cd,
                           input logic [23:0] m);
    exp_t e;
    int   i;
    e.cyc = c;
    e.tag = tag;
    e.v   = sv(s, r, f, er, cd);
    e.m   = m;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      checks++;
      assert ((((~rst_n) | clk_en) & ((~clk_en) | pll_en)) === 1'b1)
      else begin
        failures++;
        $error("FAIL order_invariant cyc=%0d got rst_n=%b clk_en=%b pll_en=%b", cyc, rst_n, clk_en, pll_en);
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk_e = sb.pop_front();
        checks++;
        assert (chk_e.cyc == cyc && (outv & chk_e.m) === (chk_e.v & chk_e.m))
        else begin
          failures++;
          $error("FAIL %s cyc=%0d got=%h exp=%h", chk_e.tag, chk_e.cyc, outv & chk_e.m, chk_e.v & chk_e.m);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "bench did not complete in time");
  end

  initial begin
    int n, k, e, l, p;
    srst = 1'b1; pwr = 1'b0; locked = 1'b0; err_clr = 1'b0;
    ref_in = 4'h0; fb_in = 12'h000;
    tick();
    expect_at(cyc, "reset", S_OFF, 4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    srst = 1'b0;
    tick();
    expect_at(cyc, "idle", S_OFF, 4'h0, 12'h000, 1'b0, 2'b00, M_ALL);

    // Nominal power-up, lock at N+5, divider change after N ignored
    n = cyc; ref_in = 4'h2; fb_in = 12'h064; pwr = 1'b1;
    expect_at(n + 1,  "up_cfg",      S_CFG,    4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 2,  "up_pll_en",   S_WAIT,   4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 5,  "up_wait",     S_WAIT,   4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 6,  "up_clk_en",   S_SETTLE, 4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 9,  "up_settle",   S_SETTLE, 4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 10, "up_rst_hold", S_HOLD,   4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 17, "up_hold_end", S_HOLD,   4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 18, "up_ready",    S_RUN,    4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(n + 19, "up_run",      S_RUN,    4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    tick();
    ref_in = 4'h5; fb_in = 12'hABC;
    wait_until(n + 5); locked = 1'b1;
    wait_until(n + 20);

    // Nominal power-down
    k = cyc; pwr = 1'b0;
    expect_at(k + 1,  "dn_rst",      S_RASSERT, 4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(k + 8,  "dn_rst_end",  S_RASSERT, 4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(k + 9,  "dn_clk_off",  S_CKOFF,   4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(k + 12, "dn_clk_end",  S_CKOFF,   4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(k + 13, "dn_pll_off",  S_PLLOFF,  4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    expect_at(k + 14, "dn_off",      S_OFF,     4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    wait_until(k + 15); locked = 1'b0;

    // Lock timeout, clear, automatic restart
    n = cyc; ref_in = 4'h7; fb_in = 12'h3FF; pwr = 1'b1;
    expect_at(n + 1,  "to_cfg",      S_CFG,  4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    expect_at(n + 2,  "to_wait",     S_WAIT, 4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    expect_at(n + 33, "to_last",     S_WAIT, 4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    expect_at(n + 34, "to_err",      S_ERR,  4'h7, 12'h3FF, 1'b1, 2'b01, M_ALL);
    expect_at(n + 40, "to_err_hold", S_ERR,  4'h7, 12'h3FF, 1'b1, 2'b01, M_ALL);
    wait_until(n + 40);
    e = cyc; err_clr = 1'b1;
    expect_at(e + 1,  "to_clr",      S_OFF,    4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    expect_at(e + 2,  "to_restart",  S_CFG,    4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    expect_at(e + 3,  "rs_wait",     S_WAIT,   4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    expect_at(e + 4,  "rs_settle",   S_SETTLE, 4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    expect_at(e + 16, "rs_ready",    S_RUN,    4'h7, 12'h3FF, 1'b0, 2'b00, M_ALL);
    tick(); err_clr = 1'b0;
    wait_until(e + 3); locked = 1'b1;
    wait_until(e + 17);

    // Lock lost in RUN with request still high
    l = cyc; locked = 1'b0;
    expect_at(l + 1,  "ll_rst",      S_RASSERT, 4'h7, 12'h3FF, 1'b0, 2'b00, M_NOERR);
    expect_at(l + 9,  "ll_clk_off",  S_CKOFF,   4'h7, 12'h3FF, 1'b0, 2'b00, M_NOERR);
    expect_at(l + 13, "ll_pll_off",  S_PLLOFF,  4'h7, 12'h3FF, 1'b0, 2'b00, M_NOERR);
    expect_at(l + 14, "ll_err",      S_ERR,     4'h7, 12'h3FF, 1'b1, 2'b10, M_ALL);
    expect_at(l + 18, "ll_ign_req",  S_ERR,     4'h7, 12'h3FF, 1'b1, 2'b10, M_ALL);
    expect_at(l + 19, "ll_clr",      S_OFF,     4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    wait_until(l + 18); err_clr = 1'b1; pwr = 1'b0;
    tick(); err_clr = 1'b0;

    // Lock and request falling together still reports lock loss
    n = cyc; ref_in = 4'h2; fb_in = 12'h064; pwr = 1'b1;
    expect_at(n + 15, "ll2_ready",   S_RUN,     4'h2, 12'h064, 1'b0, 2'b00, M_ALL);
    wait_until(n + 2); locked = 1'b1;
    wait_until(n + 16);
    p = cyc; pwr = 1'b0; locked = 1'b0;
    expect_at(p + 1,  "ll2_rst",     S_RASSERT, 4'h2, 12'h064, 1'b0, 2'b00, M_NOERR);
    expect_at(p + 13, "ll2_pll_off", S_PLLOFF,  4'h2, 12'h064, 1'b0, 2'b00, M_NOERR);
    expect_at(p + 14, "ll2_err",     S_ERR,     4'h2, 12'h064, 1'b1, 2'b10, M_ALL);
    expect_at(p + 16, "ll2_clr",     S_OFF,     4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    wait_until(p + 15); err_clr = 1'b1;
    tick(); err_clr = 1'b0;

    // Abort in the 3rd cycle of RST_HOLD
    n = cyc; ref_in = 4'h9; fb_in = 12'h555; pwr = 1'b1; locked = 1'b1;
    expect_at(n + 3,  "ab_settle",   S_SETTLE, 4'h9, 12'h555, 1'b0, 2'b00, M_ALL);
    expect_at(n + 7,  "ab_hold1",    S_HOLD,   4'h9, 12'h555, 1'b0, 2'b00, M_ALL);
    expect_at(n + 9,  "ab_hold3",    S_HOLD,   4'h9, 12'h555, 1'b0, 2'b00, M_ALL);
    for (int i = 10; i <= 13; i++)
      expect_at(n + i, "ab_clk_off", S_CKOFF,  4'h9, 12'h555, 1'b0, 2'b00, M_ALL);
    expect_at(n + 14, "ab_pll_off",  S_PLLOFF, 4'h9, 12'h555, 1'b0, 2'b00, M_ALL);
    expect_at(n + 15, "ab_off",      S_OFF,    4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    wait_until(n + 9); pwr = 1'b0;
    wait_until(n + 16);

    // Synchronous reset during CLK_SETTLE, then a clean re-request
    n = cyc; ref_in = 4'h3; fb_in = 12'h123; pwr = 1'b1;
    expect_at(n + 3,  "sr_settle",   S_SETTLE, 4'h3, 12'h123, 1'b0, 2'b00, M_ALL);
    expect_at(n + 5,  "sr_reset",    S_OFF,    4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    expect_at(n + 6,  "sr_cfg",      S_CFG,    4'h3, 12'h123, 1'b0, 2'b00, M_ALL);
    expect_at(n + 8,  "sr_settle2",  S_SETTLE, 4'h3, 12'h123, 1'b0, 2'b00, M_ALL);
    expect_at(n + 20, "sr_ready",    S_RUN,    4'h3, 12'h123, 1'b0, 2'b00, M_ALL);
    wait_until(n + 4); srst = 1'b1;
    tick(); srst = 1'b0;
    wait_until(n + 21);
    k = cyc; pwr = 1'b0;
    expect_at(k + 14, "sr_dn_off",   S_OFF,    4'h0, 12'h000, 1'b0, 2'b00, M_ALL);
    wait_until(k + 15);

    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
